// File: rtl/semaphore_ctrl.sv
// Multi-approach traffic-light controller: round-robin ALL_RED/RED_YEL/GREEN/YELLOW
// sequencing with timed or manual advance, a frame-wide freeze, and a flashing-yellow night mode.
module semaphore_ctrl #(
  parameter int NUM_DIR   = 2,
  parameter int CNT_W     = 8,
  parameter int T_ALL_RED = 2,
  parameter int T_RED_YEL = 2,
  parameter int T_GREEN   = 8,
  parameter int T_YELLOW  = 3,
  parameter int FLASH_T   = 4,
  localparam int DIR_W    = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               auto,
  input  logic               next,
  input  logic               night,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DIR_W-1:0]   active_dir,
  output logic               done
);

  localparam logic [2:0] ST_ALL_RED = 3'd0;
  localparam logic [2:0] ST_RED_YEL = 3'd1;
  localparam logic [2:0] ST_GREEN   = 3'd2;
  localparam logic [2:0] ST_YELLOW  = 3'd3;
  localparam logic [2:0] ST_NIGHT   = 3'd4;

  localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_RED_YEL = CNT_W'(T_RED_YEL - 1);
  localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(FLASH_T - 1);
  localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(NUM_DIR - 1);

  logic [2:0]       state;
  logic [DIR_W-1:0] dir;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] flash_cnt;
  logic             flash_on;
  logic             next_q;
  logic             advance;
  logic [2:0]       state_nxt;

  function automatic logic [CNT_W-1:0] phase_load(input logic [2:0] s);
    case (s)
      ST_RED_YEL: return LD_RED_YEL;
      ST_GREEN:   return LD_GREEN;
      ST_YELLOW:  return LD_YELLOW;
      default:    return LD_ALL_RED;
    endcase
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = ST_ALL_RED;
    case (state)
      ST_ALL_RED: state_nxt = ST_RED_YEL;
      ST_RED_YEL: state_nxt = ST_GREEN;
      ST_GREEN:   state_nxt = ST_YELLOW;
      default:    state_nxt = ST_ALL_RED;
    endcase
  end

  assign advance = auto ? (timer == '0) : (next & ~next_q);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ALL_RED;
      dir       <= '0;
      timer     <= LD_ALL_RED;
      flash_cnt <= '0;
      flash_on  <= 1'b0;
      next_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      // next_q tracks next even while frozen, so an edge seen during en=0 is consumed.
      next_q <= next;
      done   <= 1'b0;
      if (en) begin
        if (night) begin
          state <= ST_NIGHT;
          if (state != ST_NIGHT) begin
            flash_on  <= 1'b1;
            flash_cnt <= LD_FLASH;
          end else if (flash_cnt == '0) begin
            flash_on  <= ~flash_on;
            flash_cnt <= LD_FLASH;
          end else begin
            flash_cnt <= flash_cnt - 1'b1;
          end
        end else if (state == ST_NIGHT) begin
          state <= ST_ALL_RED;
          dir   <= '0;
          timer <= LD_ALL_RED;
        end else if (advance) begin
          state <= state_nxt;
          timer <= phase_load(state_nxt);
          if (state == ST_YELLOW) begin
            dir  <= (dir == LAST_DIR) ? '0 : dir + 1'b1;
            done <= (dir == LAST_DIR);
          end
        end else if (auto && timer != '0) begin
          timer <= timer - 1'b1;
        end
      end
    end
  end

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    case (state)
      ST_NIGHT: begin
        red    = '0;
        yellow = {NUM_DIR{flash_on}};
      end
      ST_RED_YEL: yellow[dir] = 1'b1;
      ST_GREEN: begin
        red[dir]   = 1'b0;
        green[dir] = 1'b1;
      end
      ST_YELLOW: begin
        red[dir]    = 1'b0;
        yellow[dir] = 1'b1;
      end
      default: ;
    endcase
  end

  assign active_dir = dir;

endmodule

// File: tb/tb_semaphore_ctrl.sv
// Scoreboard bench for semaphore_ctrl: a phase-level reference model queues the expected
// lamps after every edge and a negedge monitor compares them against the DUT.
module tb_semaphore_ctrl;

  localparam int N         = 2;
  localparam int T_ALL_RED = 2;
  localparam int T_RED_YEL = 2;
  localparam int T_GREEN   = 8;
  localparam int T_YELLOW  = 3;
  localparam int FLASH_T   = 4;

  typedef struct packed {
    logic [N-1:0] r;
    logic [N-1:0] y;
    logic [N-1:0] g;
    logic         ad;
    logic         d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, en, auto, next, night;
  logic [N-1:0] red, yellow, green;
  logic         active_dir;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  semaphore_ctrl #(
    .NUM_DIR(N), .CNT_W(8), .T_ALL_RED(T_ALL_RED), .T_RED_YEL(T_RED_YEL),
    .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .auto(auto), .next(next), .night(night),
    .red(red), .yellow(yellow), .green(green), .active_dir(active_dir), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: phase index 0..3 (all-red, red-yellow, green, yellow), cycles spent in
  // the phase, and cycles spent in night mode; lamps follow directly from those.
  int  m_phase = 0, m_dir = 0, m_elapsed = 0, m_night_cyc = 0;
  bit  m_in_night = 0, m_prev_next = 0, m_done = 0;

  function automatic int dur(input int p);
    case (p)
      0: return T_ALL_RED;
      1: return T_RED_YEL;
      2: return T_GREEN;
      default: return T_YELLOW;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit   edge_seen, adv;
    if (reset) begin
      m_phase = 0; m_dir = 0; m_elapsed = 0; m_prev_next = 0; m_done = 0; m_in_night = 0;
    end else begin
      edge_seen   = next && !m_prev_next;
      m_prev_next = next;
      m_done      = 0;
      if (en) begin
        if (night) begin
          if (m_in_night) m_night_cyc++;
          else m_night_cyc = 0;
          m_in_night = 1;
        end else if (m_in_night) begin
          m_in_night = 0; m_phase = 0; m_dir = 0; m_elapsed = 0;
        end else begin
          adv = auto ? (m_elapsed + 1 >= dur(m_phase)) : edge_seen;
          if (adv) begin
            if (m_phase == 3) begin
              if (m_dir == N - 1) m_done = 1;
              m_dir = (m_dir + 1) % N;
            end
            m_phase   = (m_phase + 1) % 4;
            m_elapsed = 0;
          end else if (auto) begin
            m_elapsed++;
          end
        end
      end
    end
    e.r = '1; e.y = '0; e.g = '0;
    if (m_in_night) begin
      e.r = '0;
      e.y = ((m_night_cyc / FLASH_T) % 2 == 0) ? '1 : '0;
    end else begin
      e.y[m_dir] = (m_phase == 1 || m_phase == 3);
      e.g[m_dir] = (m_phase == 2);
      e.r[m_dir] = (m_phase <= 1);
    end
    e.ad = 1'(m_dir);
    e.d  = m_done;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("red",        32'(red),        32'(e.r));
      check("yellow",     32'(yellow),     32'(e.y));
      check("green",      32'(green),      32'(e.g));
      check("active_dir", 32'(active_dir), 32'(e.ad));
      check("done",       32'(done),       32'(e.d));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int first_done, second_done, k;
    reset = 1'b1; en = 1'b1; auto = 1'b1; next = 1'b0; night = 1'b0;
    cyc(2);
    check("reset_red",  32'(red),        32'h3);
    check("reset_yel",  32'(yellow),     32'h0);
    check("reset_grn",  32'(green),      32'h0);
    check("reset_dir",  32'(active_dir), 32'h0);
    check("reset_done", 32'(done),       32'h0);

    // Auto round: done after 30 and 60 enabled cycles.
    reset = 1'b0;
    first_done = -1; second_done = -1;
    for (int i = 1; i <= 62; i++) begin
      cyc(1);
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    check("done_first",  32'(first_done),  32'd30);
    check("done_second", 32'(second_done), 32'd60);

    // Manual walk: four pulses, then next held for five cycles.
    reset = 1'b1; cyc(1); reset = 1'b0; auto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next = 1'b1; cyc(1); next = 1'b0; cyc(2);
    end
    check("manual_dir", 32'(active_dir), 32'h1);
    check("manual_red", 32'(red),        32'h3);
    next = 1'b1; cyc(5); next = 1'b0; cyc(2);
    check("held_next_yel", 32'(yellow), 32'h2);

    // Back to auto, then freeze mid-green with 4 left on the timer.
    auto = 1'b1;
    k = 0;
    do begin cyc(1); k++; end while (green == '0 && k < 40);
    check("green_reached", 32'(green != '0), 32'h1);
    cyc(3);
    en = 1'b0; cyc(10); en = 1'b1;
    k = 0;
    do begin cyc(1); k++; end while (green != '0 && k < 20);
    check("green_after_freeze", 32'(k), 32'd5);

    // Night mode entered mid-green.
    k = 0;
    do begin cyc(1); k++; end while (green == '0 && k < 40);
    night = 1'b1; cyc(20);
    check("night_red",   32'(red),   32'h0);
    check("night_green", 32'(green), 32'h0);
    night = 1'b0; cyc(1);
    check("night_exit_dir", 32'(active_dir), 32'h0);
    check("night_exit_red", 32'(red),        32'h3);

    // Reset on the edge where dir1 would leave yellow and raise done.
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(29);
    check("pre_reset_yel", 32'(yellow), 32'h2);
    reset = 1'b1; cyc(1);
    check("midreset_done", 32'(done), 32'h0);
    check("midreset_red",  32'(red),  32'h3);
    reset = 1'b0;

    // Randomised mix of freeze, mode, manual pulses, night and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(9) != 0);
      next  = 1'($urandom_range(1));
      if ($urandom_range(19) == 0)  auto  = ~auto;
      if ($urandom_range(149) == 0) night = ~night;
      reset = ($urandom_range(399) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
